// File: rtl/alu_issue_unit.sv
// alu_issue_unit: registered issue/writeback front end for the 4-bit combinational ALU.
// Accepts one instruction per three cycles (IDLE -> EXEC -> WB), reads two operands
// from a small register file, drives the ALU, captures its result and flags, and
// writes the result back while holding the architectural carry and zero flags.
// Optional macro ALU_DBG_PORT_EN adds a combinational register-file read port
// (dbg_sel / dbg_data); with it undefined, those ports do not exist.
module alu_issue_unit #(
  parameter int DW = 4,
  parameter int RW = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3*RW+3:0]   in_instr,
  output logic [DW-1:0]     alu_a,
  output logic [DW-1:0]     alu_b,
  output logic [2:0]        alu_op,
  input  logic [DW-1:0]     alu_result,
  input  logic              alu_carr,
  input  logic              alu_zero,
  output logic              done,
  output logic [DW-1:0]     wb_data,
  output logic              flag_c,
  output logic              flag_z,
  output logic              busy
`ifdef ALU_DBG_PORT_EN
  ,
  input  logic [RW-1:0]     dbg_sel,
  output logic [DW-1:0]     dbg_data
`endif
);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    EXEC = 2'b01,
    WB   = 2'b10
  } state_t;

  state_t state, state_d;

  logic [DW-1:0] regs [2**RW];
  logic [RW-1:0] rd_q;
  logic          c_q;
  logic          z_q;

  logic            ldi;
  logic [2:0]      op;
  logic [RW-1:0]   rd;
  logic [RW-1:0]   rs1;
  logic [RW-1:0]   rs2;
  logic [2*RW-1:0] imm_raw;
  logic [DW-1:0]   imm;

  assign {ldi, op, rd, rs1, rs2} = in_instr;
  assign imm_raw = {rs1, rs2};

  // The immediate is the concatenated source fields, fitted to the data width.
  generate
    if (2 * RW >= DW) begin : g_imm_trunc
      assign imm = imm_raw[DW-1:0];
    end else begin : g_imm_ext
      assign imm = {{(DW - 2 * RW){1'b0}}, imm_raw};
    end
  endgenerate

  assign in_ready = (state == IDLE);
  assign busy     = (state != IDLE);
  assign done     = (state == WB);

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_d;
  end

  // Next-state logic: a fixed three-cycle walk once an instruction is accepted.
  always_comb begin
    state_d = state;
    case (state)
      IDLE:    if (in_valid) state_d = EXEC;
      EXEC:    state_d = WB;
      WB:      state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath: operand issue on accept, result capture in EXEC, writeback in WB.
  always_ff @(posedge clk) begin
    if (rst) begin
      regs    <= '{default: '0};
      alu_a   <= '0;
      alu_b   <= '0;
      alu_op  <= '0;
      rd_q    <= '0;
      wb_data <= '0;
      c_q     <= 1'b0;
      z_q     <= 1'b0;
      flag_c  <= 1'b0;
      flag_z  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            if (ldi) begin
              alu_a  <= imm;
              alu_b  <= '0;
              alu_op <= 3'b000;
            end else begin
              alu_a  <= regs[rs1];
              alu_b  <= regs[rs2];
              alu_op <= op;
            end
            rd_q <= rd;
          end
        end
        EXEC: begin
          wb_data <= alu_result;
          c_q     <= alu_carr;
          z_q     <= alu_zero;
        end
        WB: begin
          regs[rd_q] <= wb_data;
          flag_c     <= c_q;
          flag_z     <= z_q;
        end
        default: ;
      endcase
    end
  end

`ifdef ALU_DBG_PORT_EN
  assign dbg_data = regs[dbg_sel];
`else
  // No observation port: the register file is visible only through instructions.
`endif

endmodule

// File: tb/tb_alu_issue_unit.sv
// Testbench for alu_issue_unit: directed vector table, hand-written handshake and
// reset sequences, and randomized instructions checked against a register-level model.
module tb_alu_issue_unit;

  localparam int DW = 4;
  localparam int RW = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [9:0]  in_instr;
  logic [3:0]  alu_a;
  logic [3:0]  alu_b;
  logic [2:0]  alu_op;
  logic [3:0]  alu_result;
  logic        alu_carr;
  logic        alu_zero;
  logic        done;
  logic [3:0]  wb_data;
  logic        flag_c;
  logic        flag_z;
  logic        busy;

  int n_checks = 0;
  int n_fail   = 0;

  logic [3:0] m_r [4];
  logic       m_c;
  logic       m_z;

  typedef struct {
    logic       ldi;
    logic [2:0] op;
    logic [1:0] rd;
    logic [1:0] rs1;
    logic [1:0] rs2;
    logic [3:0] exp_wb;
    logic       exp_c;
    logic       exp_z;
  } vec_t;

  vec_t vecs [8];

  alu_issue_unit #(.DW(DW), .RW(RW)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_instr   (in_instr),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_op     (alu_op),
    .alu_result (alu_result),
    .alu_carr   (alu_carr),
    .alu_zero   (alu_zero),
    .done       (done),
    .wb_data    (wb_data),
    .flag_c     (flag_c),
    .flag_z     (flag_z),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  // Behavioural ALU: returns {carry, zero, result[3:0]} from plain integer arithmetic.
  function automatic logic [5:0] alu_fn(input logic [2:0] op, input logic [3:0] a, input logic [3:0] b);
    int ai = int'(a);
    int bi = int'(b);
    int r  = 0;
    logic c = 1'b0;
    case (op)
      3'd0: begin r = ai + bi; c = (r > 15); end
      3'd1: begin r = ai - bi; c = (ai < bi); end
      3'd2: r = ai & bi;
      3'd3: r = ai | bi;
      3'd4: r = ai ^ bi;
      3'd5: r = ~ai;
      3'd6: begin r = ai * 2; c = (ai >= 8); end
      default: begin r = ai / 2; c = (ai % 2 == 1); end
    endcase
    r = r & 15;
    return {c, (r == 0), r[3:0]};
  endfunction

  // The ALU the unit drives, modelled combinationally.
  always_comb begin
    {alu_carr, alu_zero, alu_result} = alu_fn(alu_op, alu_a, alu_b);
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Issue one instruction and follow it through EXEC, WB and back to IDLE.
  task automatic applyStimulus(input logic ldi, input logic [2:0] op, input logic [1:0] rd,
                               input logic [1:0] rs1, input logic [1:0] rs2,
                               input logic [3:0] exp_wb, input logic exp_c, input logic exp_z);
    logic [3:0] ea;
    logic [3:0] eb;
    logic [2:0] eop;
    int waited = 0;
    ea  = ldi ? {rs1, rs2} : m_r[rs1];
    eb  = ldi ? 4'h0 : m_r[rs2];
    eop = ldi ? 3'b000 : op;
    @(negedge clk);
    while (!in_ready && waited < 10) begin
      @(negedge clk);
      waited++;
    end
    checkOutput("ready_before_accept", in_ready, 1);
    in_valid = 1'b1;
    in_instr = {ldi, op, rd, rs1, rs2};
    @(negedge clk);
    in_valid = 1'b0;
    in_instr = 10'($urandom);
    checkOutput("exec_busy", busy, 1);
    checkOutput("exec_ready", in_ready, 0);
    checkOutput("exec_done", done, 0);
    checkOutput("exec_alu_a", alu_a, ea);
    checkOutput("exec_alu_b", alu_b, eb);
    checkOutput("exec_alu_op", alu_op, eop);
    @(negedge clk);
    checkOutput("wb_done", done, 1);
    checkOutput("wb_data", wb_data, exp_wb);
    @(negedge clk);
    checkOutput("idle_done", done, 0);
    checkOutput("idle_ready", in_ready, 1);
    checkOutput("flag_c", flag_c, exp_c);
    checkOutput("flag_z", flag_z, exp_z);
    m_r[rd] = exp_wb;
    m_c = exp_c;
    m_z = exp_z;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not complete");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [5:0] r;
    logic       ldi;
    logic [2:0] op;
    logic [1:0] rd, rs1, rs2;

    vecs[0] = '{1'b1, 3'b000, 2'd1, 2'b10, 2'b01, 4'h9, 1'b0, 1'b0};
    vecs[1] = '{1'b1, 3'b000, 2'd2, 2'b10, 2'b00, 4'h8, 1'b0, 1'b0};
    vecs[2] = '{1'b0, 3'b000, 2'd3, 2'd1,  2'd2,  4'h1, 1'b1, 1'b0};
    vecs[3] = '{1'b1, 3'b000, 2'd0, 2'b01, 2'b01, 4'h5, 1'b0, 1'b0};
    vecs[4] = '{1'b1, 3'b000, 2'd1, 2'b01, 2'b01, 4'h5, 1'b0, 1'b0};
    vecs[5] = '{1'b0, 3'b001, 2'd2, 2'd0,  2'd1,  4'h0, 1'b0, 1'b1};
    vecs[6] = '{1'b1, 3'b000, 2'd1, 2'b11, 2'b00, 4'hC, 1'b0, 1'b0};
    vecs[7] = '{1'b0, 3'b110, 2'd1, 2'd1,  2'd0,  4'h8, 1'b1, 1'b0};

    foreach (m_r[i]) m_r[i] = 4'h0;
    m_c = 1'b0;
    m_z = 1'b0;

    // Reset and idle state.
    rst = 1'b1;
    in_valid = 1'b0;
    in_instr = '0;
    repeat (2) @(negedge clk);
    checkOutput("rst_ready", in_ready, 1);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_done", done, 0);
    checkOutput("rst_wb_data", wb_data, 0);
    checkOutput("rst_flag_c", flag_c, 0);
    checkOutput("rst_flag_z", flag_z, 0);
    checkOutput("rst_alu_a", alu_a, 0);
    checkOutput("rst_alu_b", alu_b, 0);
    checkOutput("rst_alu_op", alu_op, 0);
    rst = 1'b0;

    // Directed vectors: LDI/ADD with carry, SUB to zero, SHL self-overwrite.
    for (int i = 0; i < 8; i++) begin
      applyStimulus(vecs[i].ldi, vecs[i].op, vecs[i].rd, vecs[i].rs1, vecs[i].rs2,
                    vecs[i].exp_wb, vecs[i].exp_c, vecs[i].exp_z);
    end
    // SHR of the freshly written R1 (8 -> 4, no shift-out).
    applyStimulus(1'b0, 3'b111, 2'd1, 2'd1, 2'd0, 4'h4, 1'b0, 1'b0);

    // Handshake with in_valid held high: accepts every third edge, dependency forwarded.
    @(negedge clk);
    in_valid = 1'b1;
    in_instr = {1'b1, 3'b000, 2'd3, 2'b01, 2'b10};
    checkOutput("hs_ready0", in_ready, 1);
    @(negedge clk);
    in_instr = {1'b0, 3'b000, 2'd0, 2'd3, 2'd3};
    checkOutput("hs_exec0_ready", in_ready, 0);
    checkOutput("hs_exec0_a", alu_a, 4'h6);
    @(negedge clk);
    checkOutput("hs_wb0_ready", in_ready, 0);
    checkOutput("hs_wb0_done", done, 1);
    checkOutput("hs_wb0_data", wb_data, 4'h6);
    @(negedge clk);
    checkOutput("hs_ready1", in_ready, 1);
    @(negedge clk);
    in_instr = {1'b0, 3'b001, 2'd1, 2'd0, 2'd3};
    checkOutput("hs_exec1_ready", in_ready, 0);
    checkOutput("hs_exec1_a", alu_a, 4'h6);
    checkOutput("hs_exec1_b", alu_b, 4'h6);
    @(negedge clk);
    checkOutput("hs_wb1_done", done, 1);
    checkOutput("hs_wb1_data", wb_data, 4'hC);
    @(negedge clk);
    checkOutput("hs_ready2", in_ready, 1);
    @(negedge clk);
    in_valid = 1'b0;
    checkOutput("hs_exec2_a", alu_a, 4'hC);
    checkOutput("hs_exec2_b", alu_b, 4'h6);
    checkOutput("hs_exec2_op", alu_op, 3'b001);
    @(negedge clk);
    checkOutput("hs_wb2_done", done, 1);
    checkOutput("hs_wb2_data", wb_data, 4'h6);
    @(negedge clk);
    checkOutput("hs_idle_done", done, 0);
    checkOutput("hs_idle_ready", in_ready, 1);
    checkOutput("hs_flag_c", flag_c, 0);
    checkOutput("hs_flag_z", flag_z, 0);
    m_r[3] = 4'h6;
    m_r[0] = 4'hC;
    m_r[1] = 4'h6;
    m_c = 1'b0;
    m_z = 1'b0;

    // Randomized instructions against the register-level model.
    for (int i = 0; i < 40; i++) begin
      ldi = ($urandom_range(0, 3) == 0);
      op  = 3'($urandom_range(0, 7));
      rd  = 2'($urandom_range(0, 3));
      rs1 = 2'($urandom_range(0, 3));
      rs2 = 2'($urandom_range(0, 3));
      r = ldi ? alu_fn(3'b000, {rs1, rs2}, 4'h0) : alu_fn(op, m_r[rs1], m_r[rs2]);
      applyStimulus(ldi, op, rd, rs1, rs2, r[3:0], r[5], r[4]);
    end

    // Reset during EXEC discards the instruction and clears everything.
    applyStimulus(1'b1, 3'b000, 2'd3, 2'b01, 2'b11, 4'h7, 1'b0, 1'b0);
    @(negedge clk);
    in_valid = 1'b1;
    in_instr = {1'b0, 3'b000, 2'd3, 2'd3, 2'd0};
    @(negedge clk);
    in_valid = 1'b0;
    checkOutput("rm_exec_busy", busy, 1);
    rst = 1'b1;
    @(negedge clk);
    checkOutput("rm_done_in_rst", done, 0);
    checkOutput("rm_busy_in_rst", busy, 0);
    rst = 1'b0;
    @(negedge clk);
    checkOutput("rm_ready", in_ready, 1);
    checkOutput("rm_done", done, 0);
    checkOutput("rm_flag_c", flag_c, 0);
    checkOutput("rm_flag_z", flag_z, 0);
    checkOutput("rm_wb_data", wb_data, 0);
    checkOutput("rm_alu_a", alu_a, 0);
    foreach (m_r[i]) m_r[i] = 4'h0;
    m_c = 1'b0;
    m_z = 1'b0;
    // R3 must read back as zero after the reset.
    applyStimulus(1'b0, 3'b000, 2'd2, 2'd3, 2'd3, 4'h0, 1'b0, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
